pwm_timer_multi: RTL and testbench

//   Multi-channel PWM timer: variable-modulus counter with edge- or center-aligned

---
 rtl/pwm_timer_multi_if.sv | 27 ++
 rtl/pwm_timer_multi.sv | 113 +++++++++++
 tb/tb_pwm_timer_multi.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_timer_multi_if.sv
// Control/status bundle of the multi-channel PWM timer.
// The master side programs period/duty/mode and enable; the slave side is the timer.
interface pwm_timer_multi_if #(
  parameter int NBITS = 25,
  parameter int NCH   = 4
);
  logic                   iEN;
  logic                   iLOAD;
  logic                   iMODE;
  logic [NBITS-1:0]       iPERIOD;
  logic [NCH*NBITS-1:0]   iDUTY;
  logic [NBITS-1:0]       oCOUNT;
  logic                   oDIR;
  logic                   oTC;
  logic [NCH-1:0]         oPWM;
  logic                   oPEND;

  modport master (
    output iEN, iLOAD, iMODE, iPERIOD, iDUTY,
    input  oCOUNT, oDIR, oTC, oPWM, oPEND
  );

  modport slave (
    input  iEN, iLOAD, iMODE, iPERIOD, iDUTY,
    output oCOUNT, oDIR, oTC, oPWM, oPEND
  );
endinterface

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: variable-modulus up or up/down counter, NCH compare
// channels, and a shadow register set that is copied to the active set only at
// a period boundary so a running period is never cut short or stretched.
module pwm_timer_multi #(
  parameter int NBITS = 25,
  parameter int NCH   = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  pwm_timer_multi_if.slave    bus
);

  // Active (in use) settings and the shadow copy waiting for a boundary
  logic [NBITS-1:0]     r_per;
  logic [NBITS-1:0]     r_sh_per;
  logic [NCH*NBITS-1:0] r_duty;
  logic [NCH*NBITS-1:0] r_sh_duty;
  logic                 r_mode;
  logic                 r_sh_mode;
  logic                 r_pend;

  // Counter state and registered compare outputs
  logic [NBITS-1:0]     r_cnt;
  logic                 r_dir;
  logic [NCH-1:0]       r_pwm;

  logic [NBITS-1:0]     w_last;
  logic                 w_bnd;
  logic                 w_tc;
  logic                 w_xfer;
  logic [NBITS-1:0]     w_cnt_nxt;
  logic                 w_dir_nxt;
  logic [NCH*NBITS-1:0] w_duty_nxt;
  logic [NCH-1:0]       w_pwm_nxt;

  // A period of 0 behaves as 1, so the terminal count is never formed from 0-1
  assign w_last = (r_per == '0) ? '0 : (r_per - NBITS'(1));
  assign w_bnd  = r_mode ? ((r_cnt == '0) && r_dir) : (r_cnt == w_last);
  assign w_tc   = w_bnd & bus.iEN & ~iRST;
  assign w_xfer = w_tc & r_pend;

  // Next count/direction, and PWM compare against the count the flops will hold
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_pwm_nxt  = '0;
    if (bus.iEN) begin
      if (w_bnd) begin
        w_cnt_nxt = '0;
        w_dir_nxt = 1'b0;
      end else if (!r_mode) begin
        w_cnt_nxt = r_cnt + NBITS'(1);
      end else if (!r_dir) begin
        // Top value is held for a second cycle while the direction flips
        if (r_cnt == w_last) w_dir_nxt = 1'b1;
        else                 w_cnt_nxt = r_cnt + NBITS'(1);
      end else begin
        w_cnt_nxt = r_cnt - NBITS'(1);
      end
    end
    w_duty_nxt = w_xfer ? r_sh_duty : r_duty;
    for (int k = 0; k < NCH; k++) begin
      w_pwm_nxt[k] = (w_cnt_nxt < w_duty_nxt[k*NBITS +: NBITS]);
    end
  end

  // Counter, direction and PWM output flops
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_pwm <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
      r_pwm <= w_pwm_nxt;
    end
  end

  // Shadow capture, boundary transfer and pending flag (a new load keeps it set)
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_per     <= '0;
      r_duty    <= '0;
      r_mode    <= 1'b0;
      r_sh_per  <= '0;
      r_sh_duty <= '0;
      r_sh_mode <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_per  <= r_sh_per;
        r_duty <= r_sh_duty;
        r_mode <= r_sh_mode;
      end
      if (bus.iLOAD) begin
        r_sh_per  <= bus.iPERIOD;
        r_sh_duty <= bus.iDUTY;
        r_sh_mode <= bus.iMODE;
        r_pend    <= 1'b1;
      end else if (w_xfer) begin
        r_pend    <= 1'b0;
      end
    end
  end

  assign bus.oCOUNT = r_cnt;
  assign bus.oDIR   = r_dir;
  assign bus.oTC    = w_tc;
  assign bus.oPWM   = r_pwm;
  assign bus.oPEND  = r_pend;

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Testbench for pwm_timer_multi: directed scenarios plus randomized traffic,
// all compared against a period-position reference model.
module tb_pwm_timer_multi;
  localparam int NB = 25;
  localparam int NC = 4;
  localparam int VW = NB + NC + 3;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  pwm_timer_multi_if #(.NBITS(NB), .NCH(NC)) bus ();
  pwm_timer_multi #(.NBITS(NB), .NCH(NC)) dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference model: position m_t inside the current period
  int            m_t = 0;
  logic [NB-1:0] m_per = '0, s_per = '0;
  logic          m_mode = 1'b0, s_mode = 1'b0, m_pend = 1'b0;
  logic [NB-1:0] m_duty [NC];
  logic [NB-1:0] s_duty [NC];

  function automatic int m_pc();
    return (m_per == '0) ? 1 : int'(m_per);
  endfunction
  function automatic int m_len();
    return m_mode ? 2 * m_pc() : m_pc();
  endfunction
  function automatic int m_cnt();
    if (!m_mode) return m_t;
    return (m_t < m_pc()) ? m_t : (2 * m_pc() - 1 - m_t);
  endfunction
  function automatic logic m_dir();
    return m_mode && (m_t >= m_pc());
  endfunction
  function automatic logic m_tc();
    return (m_t == m_len() - 1) && bus.iEN && !iRST;
  endfunction
  function automatic logic [NC-1:0] m_pwm();
    logic [NC-1:0] r;
    for (int k = 0; k < NC; k++) r[k] = (m_cnt() < int'(m_duty[k]));
    return r;
  endfunction
  function automatic logic [VW-1:0] exp_v();
    return {NB'(m_cnt()), m_dir(), m_tc(), m_pwm(), m_pend};
  endfunction
  function automatic logic [VW-1:0] got_v();
    return {bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND};
  endfunction

  task automatic m_step();
    logic tc, xfer;
    tc   = m_tc();
    xfer = tc && m_pend;
    if (iRST) begin
      m_t = 0; m_per = '0; s_per = '0; m_mode = 0; s_mode = 0; m_pend = 0;
      for (int k = 0; k < NC; k++) begin m_duty[k] = '0; s_duty[k] = '0; end
    end else begin
      if (bus.iEN) m_t = tc ? 0 : m_t + 1;
      if (xfer) begin
        m_per = s_per; m_mode = s_mode;
        for (int k = 0; k < NC; k++) m_duty[k] = s_duty[k];
      end
      if (bus.iLOAD) begin
        s_per = bus.iPERIOD; s_mode = bus.iMODE; m_pend = 1'b1;
        for (int k = 0; k < NC; k++) s_duty[k] = bus.iDUTY[k*NB +: NB];
      end else if (xfer) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge iCLK);
    m_step();
    @(negedge iCLK);
  endtask

  task automatic set_cfg(input int per, input logic mode, input int d3, d2, d1, d0);
    bus.iPERIOD = NB'(per);
    bus.iMODE   = mode;
    bus.iDUTY   = {NB'(d3), NB'(d2), NB'(d1), NB'(d0)};
  endtask

  // Advance until the model has just applied a transfer (or passed a boundary)
  task automatic run_to_period_start();
    logic hit;
    for (int n = 0; n < 40; n++) begin
      hit = m_tc();
      cyc();
      if (hit && !m_pend) break;
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1; bus.iEN = 1'b1; bus.iLOAD = 1'b1;
    set_cfg(6, 1'b1, 3, 3, 3, 3);
    repeat (3) cyc();
    #1;
    checks++;
    if ({bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND} !== {NB'(0), 1'b0, 1'b0, 4'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got cnt=%0d dir=%b tc=%b pwm=%b pend=%b, want all 0",
               bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND);
    end
    iRST = 1'b0; bus.iLOAD = 1'b0; bus.iEN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND} !== {NB'(0), 1'b0, 1'b0, 4'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_after c%0d: got cnt=%0d dir=%b tc=%b pwm=%b pend=%b, want all 0",
                 i, bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND);
      end
      cyc();
    end
  endtask

  task automatic test_edge();
    set_cfg(5, 1'b0, 7, 5, 0, 2);
    bus.iLOAD = 1'b1; bus.iEN = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    run_to_period_start();
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL edge_model c%0d: got=%h want=%h", i, got_v(), exp_v());
      end
      checks++;
      if ({bus.oCOUNT, bus.oTC, bus.oPWM} !== {NB'(i % 5), (i % 5) == 4, 3'b110, (i % 5) < 2}) begin
        errors++;
        $display("FAIL edge_p5 c%0d: got cnt=%0d tc=%b pwm=%b want cnt=%0d tc=%b pwm=110%b",
                 i, bus.oCOUNT, bus.oTC, bus.oPWM, i % 5, (i % 5) == 4, (i % 5) < 2);
      end
      cyc();
    end
  endtask

  task automatic test_center();
    int seq [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    set_cfg(4, 1'b1, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 2);
    bus.iLOAD = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    run_to_period_start();
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL center_model c%0d: got=%h want=%h", i, got_v(), exp_v());
      end
      checks++;
      if ({bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM[0]} !==
          {NB'(seq[i % 8]), (i % 8) >= 4, (i % 8) == 7, seq[i % 8] < 2}) begin
        errors++;
        $display("FAIL center_p4 c%0d: got cnt=%0d dir=%b tc=%b pwm0=%b want cnt=%0d",
                 i, bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM[0], seq[i % 8]);
      end
      cyc();
    end
  endtask

  task automatic test_load_midperiod();
    int cs [6] = '{2, 3, 4, 0, 1, 2};
    set_cfg(5, 1'b0, 1, 2, 3, 4);
    bus.iLOAD = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    run_to_period_start();
    cyc();
    set_cfg(3, 1'b0, 1, 1, 2, 2);
    bus.iLOAD = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL midload_model c%0d: got=%h want=%h", i, got_v(), exp_v());
      end
      checks++;
      if ({bus.oCOUNT, bus.oTC, bus.oPEND} !== {NB'(cs[i]), i == 2 || i == 5, i < 3}) begin
        errors++;
        $display("FAIL midload c%0d: got cnt=%0d tc=%b pend=%b want cnt=%0d tc=%b pend=%b",
                 i, bus.oCOUNT, bus.oTC, bus.oPEND, cs[i], i == 2 || i == 5, i < 3);
      end
      cyc();
    end
  endtask

  task automatic test_load_at_tc();
    // Entered at count 0 of a P=3 period with nothing pending
    set_cfg(3, 1'b0, 0, 0, 0, 1);
    bus.iLOAD = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    cyc();
    set_cfg(7, 1'b0, 0, 0, 0, 4);
    bus.iLOAD = 1'b1;
    #1;
    checks++;
    if ({bus.oCOUNT, bus.oTC, bus.oPEND} !== {NB'(2), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL tcload_setup: got cnt=%0d tc=%b pend=%b want cnt=2 tc=1 pend=1",
               bus.oCOUNT, bus.oTC, bus.oPEND);
    end
    cyc();
    bus.iLOAD = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL tcload_model c%0d: got=%h want=%h", i, got_v(), exp_v());
      end
      checks++;
      if ({bus.oCOUNT, bus.oPEND} !== {NB'(i < 3 ? i : i - 3), i < 3}) begin
        errors++;
        $display("FAIL tcload c%0d: got cnt=%0d pend=%b want cnt=%0d pend=%b",
                 i, bus.oCOUNT, bus.oPEND, i < 3 ? i : i - 3, i < 3);
      end
      cyc();
    end
  endtask

  task automatic test_enable_hold();
    set_cfg(5, 1'b0, 1, 3, 5, 0);
    bus.iLOAD = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    run_to_period_start();
    cyc(); cyc();
    bus.iEN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({bus.oCOUNT, bus.oTC, bus.oPWM} !== {NB'(2), 1'b0, 4'b0110}) begin
        errors++;
        $display("FAIL en_hold c%0d: got cnt=%0d tc=%b pwm=%b want cnt=2 tc=0 pwm=0110",
                 i, bus.oCOUNT, bus.oTC, bus.oPWM);
      end
      cyc();
    end
    bus.iEN = 1'b1;
    #1;
    checks++;
    if (got_v() !== exp_v()) begin
      errors++;
      $display("FAIL en_resume_model: got=%h want=%h", got_v(), exp_v());
    end
    cyc();
    #1;
    checks++;
    if (bus.oCOUNT !== NB'(3)) begin
      errors++;
      $display("FAIL en_resume: got cnt=%0d want 3", bus.oCOUNT);
    end
  endtask

  task automatic test_reset_center();
    set_cfg(4, 1'b1, 4, 3, 2, 1);
    bus.iLOAD = 1'b1;
    cyc();
    bus.iLOAD = 1'b0;
    run_to_period_start();
    repeat (5) cyc();
    #1;
    checks++;
    if ({bus.oCOUNT, bus.oDIR} !== {NB'(2), 1'b1}) begin
      errors++;
      $display("FAIL rstc_pre: got cnt=%0d dir=%b want cnt=2 dir=1", bus.oCOUNT, bus.oDIR);
    end
    bus.iLOAD = 1'b1;
    iRST = 1'b1;
    #1;
    checks++;
    if (bus.oTC !== 1'b0) begin
      errors++;
      $display("FAIL rstc_tc: got tc=%b want 0", bus.oTC);
    end
    cyc();
    iRST = 1'b0; bus.iLOAD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND} !== {NB'(0), 1'b0, 1'b1, 4'b0, 1'b0}) begin
        errors++;
        $display("FAIL rstc_post c%0d: got cnt=%0d dir=%b tc=%b pwm=%b pend=%b want 0 0 1 0000 0",
                 i, bus.oCOUNT, bus.oDIR, bus.oTC, bus.oPWM, bus.oPEND);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.iEN   = ($urandom_range(0, 9) != 0);
      bus.iLOAD = ($urandom_range(0, 14) == 0);
      iRST      = ($urandom_range(0, 99) == 0);
      set_cfg($urandom_range(0, 9), 1'($urandom_range(0, 1)), $urandom_range(0, 11),
              $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
      #1;
      checks++;
      if (got_v() !== exp_v()) begin
        errors++;
        $display("FAIL random_model c%0d: got=%h want=%h", i, got_v(), exp_v());
      end
      cyc();
    end
    iRST = 1'b0; bus.iLOAD = 1'b0;
  endtask

  initial begin
    iRST = 1'b1;
    bus.iEN = 1'b0; bus.iLOAD = 1'b0; bus.iMODE = 1'b0;
    bus.iPERIOD = '0; bus.iDUTY = '0;
    for (int k = 0; k < NC; k++) begin m_duty[k] = '0; s_duty[k] = '0; end
    @(negedge iCLK);
    test_reset();
    test_edge();
    test_center();
    test_load_midperiod();
    test_load_at_tc();
    test_enable_hold();
    test_reset_center();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
